// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement adder/subtractor.
// One full-adder cell and a carry flip-flop process one operand bit per clock,
// LSB first. A start/busy/done handshake wraps the datapath. A result appears
// WIDTH cycles after the accepting edge.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    input  logic             in_start,
    input  logic             in_sub,
    input  logic [WIDTH-1:0] in_op_a,
    input  logic [WIDTH-1:0] in_op_b,
    output logic             out_busy,
    output logic             out_done,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_load;
    logic               w_step;
    logic               w_last;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    // Holds the WIDTH-1 sum bits already produced. The final bit comes
    // straight from the adder on the completing edge.
    logic [WIDTH-2:0]   r_sum;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_s;
    logic               w_c_next;
    logic [WIDTH-1:0]   w_sum_next;

    // Full-adder cell working on the current LSBs and the carry FF.
    assign w_s        = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_c_next   = (r_a[0] & r_b[0]) | ((r_a[0] ^ r_b[0]) & r_carry);
    assign w_sum_next = {w_s, r_sum};

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, whatever order the always blocks run in.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and datapath controls; start is ignored while in RUN.
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        out_busy     = 1'b0;
        out_done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_start) begin
                    w_load       = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                out_busy = 1'b1;
                w_step   = 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_last       = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_done = 1'b1;
                if (in_start) begin
                    w_load       = 1'b1;
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Operand load, one serial step per RUN cycle, result capture on the last step.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_sum        <= '0;
            r_carry      <= 1'b0;
            r_cnt        <= '0;
            out_sum      <= '0;
            out_carry    <= 1'b0;
            out_overflow <= 1'b0;
        end else if (w_load) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
            r_a     <= in_op_a;
            r_b     <= in_sub ? ~in_op_b : in_op_b;
            r_carry <= in_sub;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_sum   <= w_sum_next[WIDTH-1:1];
            r_carry <= w_c_next;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                // On the MSB step the carry FF still holds the carry into
                // the MSB, so the signed-overflow term is formed directly.
                out_sum      <= w_sum_next;
                out_carry    <= w_c_next;
                out_overflow <= r_carry ^ w_c_next;
            end
        end
    end

endmodule
